// File: rtl/snek_game_ctrl.sv
// Purpose: snek game control core: game FSM (splash/play/pause/over), snake step timer,
//          direction arbitration with reverse rejection, eat/score/high-score bookkeeping.
// Latency: every output is registered; responses appear 1 clk after the causing input.
// Backpressure: none; buttons/dead are sampled every cycle and step/new_food/game_rst are
//               fire-and-forget pulses.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   buttons[3:0]        level: [0] right, [1] left, [2] up, [3] down
//   pause_btn           level; rising edge toggles PLAY <-> PAUSE
//   head_h/v, food_h/v  snake head and food coordinates
//   dead                collision flag from the snake generator
//   step                one-cycle pulse advancing the snake
//   dir                 committed direction: 0 left, 1 right, 2 up, 3 down
//   grow                level; snake grows on the next step
//   new_food            one-cycle pulse requesting food relocation
//   game_rst            one-cycle pulse resetting the snake generator
//   state               0 SPLASH, 1 PLAY, 2 PAUSE, 3 OVER
//   score, high_score   current score, best score since rst
module snek_game_ctrl #(
  parameter int unsigned GRID_W        = 32,
  parameter int unsigned GRID_H        = 24,
  parameter int unsigned H_BITS        = 6,
  parameter int unsigned V_BITS        = 6,
  parameter int unsigned SCORE_W       = 8,
  parameter int unsigned TICK_START    = 6250000,
  parameter int unsigned TICK_STEP     = 200000,
  parameter int unsigned TICK_MIN      = 1250000,
  parameter int unsigned SPLASH_CYCLES = 125000000,
  parameter int unsigned OVER_CYCLES   = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         buttons,
  input  logic               pause_btn,
  input  logic [H_BITS-1:0]  head_h,
  input  logic [V_BITS-1:0]  head_v,
  input  logic [H_BITS-1:0]  food_h,
  input  logic [V_BITS-1:0]  food_v,
  input  logic               dead,
  output logic               step,
  output logic [1:0]         dir,
  output logic               grow,
  output logic               new_food,
  output logic               game_rst,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam logic [1:0] ST_SPLASH = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  localparam logic [31:0] T_START   = 32'(TICK_START);
  localparam logic [31:0] T_STEP    = 32'(TICK_STEP);
  localparam logic [31:0] T_MIN     = 32'(TICK_MIN);
  localparam logic [31:0] T_HEADRM  = T_START - T_MIN;
  localparam logic [31:0] SPLASH_LS = 32'(SPLASH_CYCLES - 1);
  localparam logic [31:0] OVER_LS   = 32'(OVER_CYCLES - 1);
  localparam logic [31:0] GRID_W_L  = 32'(GRID_W);
  localparam logic [31:0] GRID_H_L  = 32'(GRID_H);

  logic [1:0]         state_q, state_d;
  logic [31:0]        timer_q, timer_d;
  logic [31:0]        step_cnt_q, step_cnt_d;
  logic [31:0]        period_q, period_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         pending_q, pending_d;
  logic               grow_q, grow_d;
  logic               eat_armed_q, eat_armed_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic               step_q, step_d;
  logic               new_food_q, new_food_d;
  logic               game_rst_q, game_rst_d;
  logic               pause_prev_q;

  logic               pause_rise;
  logic               eat_hit;
  logic               food_bad;
  logic               step_hit;
  logic               req_vld;
  logic [1:0]         req_dir;
  logic [31:0]        prod;
  logic [31:0]        period_calc;
  logic [SCORE_W-1:0] score_inc;
  logic               start_game;

  assign pause_rise = pause_btn & ~pause_prev_q;
  assign eat_hit    = (head_h == food_h) && (head_v == food_v);
  assign food_bad   = (32'(food_h) >= GRID_W_L) || (32'(food_v) >= GRID_H_L);
  assign step_hit   = (step_cnt_q == period_q - 32'd1);
  assign score_inc  = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

  // Speed curve: the subtraction is guarded so it can never underflow below the floor.
  always_comb begin
    prod = T_STEP * 32'(score_q);
    if (prod > T_HEADRM) period_calc = T_MIN;
    else                 period_calc = T_START - prod;
  end

  // Button priority left > right > up > down.
  always_comb begin
    req_vld = 1'b1;
    req_dir = 2'd0;
    if      (buttons[1]) req_dir = 2'd0;
    else if (buttons[0]) req_dir = 2'd1;
    else if (buttons[2]) req_dir = 2'd2;
    else if (buttons[3]) req_dir = 2'd3;
    else                 req_vld = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    step_cnt_d  = step_cnt_q;
    period_d    = period_q;
    dir_d       = dir_q;
    pending_d   = pending_q;
    grow_d      = grow_q;
    eat_armed_d = eat_armed_q;
    score_d     = score_q;
    high_d      = high_q;
    step_d      = 1'b0;
    new_food_d  = 1'b0;
    game_rst_d  = 1'b0;
    start_game  = 1'b0;

    // Reverse of the committed direction only differs in bit 0.
    if (req_vld && (req_dir != {dir_q[1], ~dir_q[0]})) pending_d = req_dir;

    // Re-arm after the step the snake generator used to grow; an eat in
    // this same cycle overrides it below.
    if (step_q) begin
      grow_d      = 1'b0;
      eat_armed_d = 1'b1;
    end

    case (state_q)
      ST_SPLASH: begin
        if (timer_q == SPLASH_LS) start_game = 1'b1;
        else                      timer_d    = timer_q + 32'd1;
      end
      ST_PLAY: begin
        if (step_hit) begin
          step_d     = 1'b1;
          step_cnt_d = 32'd0;
          dir_d      = pending_q;
          period_d   = period_calc;
        end else begin
          step_cnt_d = step_cnt_q + 32'd1;
        end
        if (eat_hit && eat_armed_q) begin
          new_food_d  = 1'b1;
          score_d     = score_inc;
          grow_d      = 1'b1;
          eat_armed_d = 1'b0;
        end
        if (food_bad) new_food_d = 1'b1;
        // score_d already includes a same-cycle eat; dead beats a pause edge.
        if (dead) begin
          state_d = ST_OVER;
          timer_d = 32'd0;
          if (score_d > high_q) high_d = score_d;
        end else if (pause_rise) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (food_bad)   new_food_d = 1'b1;
        if (pause_rise) state_d    = ST_PLAY;
      end
      ST_OVER: begin
        if (timer_q == OVER_LS) start_game = 1'b1;
        else                    timer_d    = timer_q + 32'd1;
      end
      default: state_d = ST_SPLASH;
    endcase

    // Fresh game: a stale grow/disarm from the previous game must not leak
    // into the regenerated snake.
    if (start_game) begin
      state_d     = ST_PLAY;
      game_rst_d  = 1'b1;
      new_food_d  = 1'b1;
      timer_d     = 32'd0;
      step_cnt_d  = 32'd0;
      period_d    = T_START;
      score_d     = '0;
      dir_d       = 2'd0;
      pending_d   = 2'd0;
      grow_d      = 1'b0;
      eat_armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SPLASH;
      timer_q      <= 32'd0;
      step_cnt_q   <= 32'd0;
      period_q     <= T_START;
      dir_q        <= 2'd0;
      pending_q    <= 2'd0;
      grow_q       <= 1'b0;
      eat_armed_q  <= 1'b1;
      score_q      <= '0;
      high_q       <= '0;
      step_q       <= 1'b0;
      new_food_q   <= 1'b0;
      game_rst_q   <= 1'b0;
      pause_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      step_cnt_q   <= step_cnt_d;
      period_q     <= period_d;
      dir_q        <= dir_d;
      pending_q    <= pending_d;
      grow_q       <= grow_d;
      eat_armed_q  <= eat_armed_d;
      score_q      <= score_d;
      high_q       <= high_d;
      step_q       <= step_d;
      new_food_q   <= new_food_d;
      game_rst_q   <= game_rst_d;
      pause_prev_q <= pause_btn;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign grow       = grow_q;
  assign new_food   = new_food_q;
  assign game_rst   = game_rst_q;
  assign state      = state_q;
  assign score      = score_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_snek_game_ctrl.sv
// Purpose: self-checking bench for snek_game_ctrl with short timing parameters.
// Latency: drives and samples 1 time unit after each rising clk edge.
// Backpressure: none; a cycle-indexed table drives inputs and checks outputs.
module tb_snek_game_ctrl;

  localparam int LAST_CYC = 146;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] buttons;
  logic       pause_btn;
  logic [5:0] head_h, head_v, food_h, food_v;
  logic       dead;
  logic       step, grow, new_food, game_rst;
  logic [1:0] dir, state;
  logic [7:0] score, high_score;

  // Head normally at (1,1), food at the legal corner (31,23).
  logic eat_s, badh_s, badv_s;
  assign head_h = eat_s  ? 6'd31 : 6'd1;
  assign head_v = eat_s  ? 6'd23 : 6'd1;
  assign food_h = badh_s ? 6'd32 : 6'd31;
  assign food_v = badv_s ? 6'd24 : 6'd23;

  always #5 clk = ~clk;

  snek_game_ctrl #(
    .GRID_W(32), .GRID_H(24), .H_BITS(6), .V_BITS(6), .SCORE_W(8),
    .TICK_START(10), .TICK_STEP(2), .TICK_MIN(4),
    .SPLASH_CYCLES(5), .OVER_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .pause_btn(pause_btn),
    .head_h(head_h), .head_v(head_v), .food_h(food_h), .food_v(food_v),
    .dead(dead), .step(step), .dir(dir), .grow(grow), .new_food(new_food),
    .game_rst(game_rst), .state(state), .score(score), .high_score(high_score)
  );

  typedef enum int {
    I_RST, I_BTN, I_PB, I_EAT, I_BADH, I_BADV, I_DEAD,
    O_STATE, O_SCORE, O_HIGH, O_DIR, O_GROW, O_NF, O_GR, O_STEP,
    X_STEP
  } kind_e;

  typedef struct {
    int    cyc;
    kind_e kind;
    int    val;
  } vec_t;

  vec_t tbl[$];
  int   step_sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(int c, kind_e k, int v);
    vec_t e;
    e.cyc = c; e.kind = k; e.val = v;
    tbl.push_back(e);
  endfunction

  // Expected step cycle, queued a few cycles before it is due.
  function automatic void exp_step(int at);
    add(at - 3, X_STEP, at);
  endfunction

  function automatic int get_out(kind_e k);
    case (k)
      O_STATE: return int'(state);
      O_SCORE: return int'(score);
      O_HIGH:  return int'(high_score);
      O_DIR:   return int'(dir);
      O_GROW:  return int'(grow);
      O_NF:    return int'(new_food);
      O_GR:    return int'(game_rst);
      O_STEP:  return int'(step);
      default: return -1;
    endcase
  endfunction

  task automatic check(string nm, int c, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, c, act, exp);
    end
  endtask

  task automatic drive(kind_e k, int v);
    case (k)
      I_RST:   rst       = v[0];
      I_BTN:   buttons   = v[3:0];
      I_PB:    pause_btn = v[0];
      I_EAT:   eat_s     = v[0];
      I_BADH:  badh_s    = v[0];
      I_BADV:  badv_s    = v[0];
      I_DEAD:  dead      = v[0];
      X_STEP:  step_sb.push_back(v);
      default: ;
    endcase
  endtask

  initial begin
    // ---- reset state and splash ----
    add(0, O_STATE, 0); add(0, O_SCORE, 0); add(0, O_HIGH, 0); add(0, O_DIR, 0);
    add(0, O_GROW, 0);  add(0, O_NF, 0);    add(0, O_GR, 0);   add(0, O_STEP, 0);
    add(0, I_RST, 0);
    add(1, I_BTN, 1); add(1, I_EAT, 1);     // right is the reverse of left: rejected
    add(4, O_STATE, 0);
    add(5, O_STATE, 1); add(5, O_GR, 1); add(5, O_NF, 1); add(5, O_SCORE, 0);
    // ---- held head on food across the first step: one eat only ----
    add(6, O_GR, 0); add(6, O_NF, 1); add(6, O_SCORE, 1); add(6, O_GROW, 1);
    add(7, O_NF, 0);
    exp_step(15);
    add(15, O_GROW, 1); add(15, O_DIR, 0);
    add(16, O_GROW, 0); add(16, O_SCORE, 1); add(16, O_DIR, 0);
    add(16, I_EAT, 0);  add(16, I_BTN, 4);
    add(17, O_SCORE, 1);
    // ---- speed curve: spacing 10, 8, 6, 4, 4 ----
    add(18, I_EAT, 1);
    add(19, I_EAT, 0); add(19, O_SCORE, 2); add(19, O_GROW, 1);
    add(21, I_BTN, 0);
    add(22, O_DIR, 0);
    exp_step(23);
    add(23, O_DIR, 2); add(23, O_GROW, 1);
    add(24, O_GROW, 0); add(24, I_BTN, 5);  // right+up: right wins
    add(25, I_EAT, 1);
    add(26, I_EAT, 0); add(26, O_SCORE, 3);
    add(28, I_BTN, 0);
    exp_step(29);
    add(29, O_DIR, 1); add(29, I_BTN, 2);   // left is the reverse of right
    add(30, I_EAT, 1); add(30, O_GROW, 0);
    add(31, I_EAT, 0); add(31, O_SCORE, 4); add(31, O_GROW, 1);
    exp_step(33);
    add(33, O_DIR, 1);
    add(34, I_BTN, 4); add(34, I_EAT, 1);
    add(35, I_EAT, 0); add(35, O_SCORE, 5); add(35, O_NF, 1);
    add(36, O_NF, 0);
    exp_step(37);
    add(37, O_DIR, 2); add(37, I_BTN, 0);
    exp_step(41);
    // ---- pause for 20 cycles mid-period ----
    add(42, I_PB, 1);
    add(43, O_STATE, 2);
    add(45, I_BTN, 1);                      // latched while paused
    add(47, I_BTN, 0);
    add(50, I_EAT, 1);                      // eat frozen while paused
    add(51, I_PB, 0); add(51, O_NF, 0);
    add(53, I_EAT, 0); add(53, O_SCORE, 5); add(53, O_GROW, 0);
    add(55, I_BADH, 1);                     // food_h == GRID_W
    add(56, I_BADH, 0); add(56, I_BADV, 1); add(56, O_NF, 1);
    add(57, I_BADV, 0); add(57, O_NF, 1);
    add(58, O_NF, 0); add(58, O_SCORE, 5);
    add(62, I_PB, 1); add(62, O_STATE, 2);
    add(63, O_STATE, 1);
    add(64, O_DIR, 2); add(64, I_PB, 0);
    exp_step(65);
    add(65, O_DIR, 1);
    // ---- dead + eat + pause edge in one cycle ----
    add(67, I_DEAD, 1); add(67, I_EAT, 1); add(67, I_PB, 1);
    add(68, O_STATE, 3); add(68, O_SCORE, 6); add(68, O_HIGH, 6);
    add(68, I_PB, 0); add(68, I_EAT, 0);
    add(69, I_PB, 1); add(69, O_STATE, 3);  // pause edge and dead ignored in OVER
    add(70, I_PB, 0); add(70, I_DEAD, 0); add(70, O_STATE, 3);
    add(71, O_STATE, 1); add(71, O_GR, 1); add(71, O_NF, 1);
    add(71, O_SCORE, 0); add(71, O_HIGH, 6); add(71, O_DIR, 0);
    add(72, O_GR, 0); add(72, O_STATE, 1);
    // ---- rst mid-game clears high score ----
    add(75, I_RST, 1);
    add(76, O_STATE, 0); add(76, O_HIGH, 0); add(76, O_SCORE, 0); add(76, O_DIR, 0);
    add(77, I_RST, 0);
    add(81, O_STATE, 0);
    add(82, O_STATE, 1); add(82, O_GR, 1);
    // ---- game to score 3, die ----
    add(83, I_EAT, 1);
    add(84, I_EAT, 0); add(84, O_SCORE, 1);
    exp_step(92);
    add(93, I_EAT, 1);
    add(94, I_EAT, 0); add(94, O_SCORE, 2);
    exp_step(100);
    add(101, I_EAT, 1);
    add(102, I_EAT, 0); add(102, O_SCORE, 3); add(102, O_HIGH, 0);
    add(103, I_DEAD, 1);
    add(104, I_DEAD, 0); add(104, O_STATE, 3); add(104, O_HIGH, 3); add(104, O_SCORE, 3);
    add(106, O_STATE, 3);
    add(107, O_STATE, 1); add(107, O_GR, 1); add(107, O_SCORE, 0); add(107, O_HIGH, 3);
    // ---- game to score 2, die: high score kept ----
    exp_step(117);
    add(118, I_EAT, 1);
    add(119, I_EAT, 0); add(119, O_SCORE, 1);
    exp_step(127);
    add(128, I_EAT, 1);
    add(129, I_EAT, 0); add(129, O_SCORE, 2);
    add(130, I_DEAD, 1);
    add(131, I_DEAD, 0); add(131, O_STATE, 3); add(131, O_HIGH, 3); add(131, O_SCORE, 2);
    add(134, O_STATE, 1); add(134, O_GR, 1); add(134, O_SCORE, 0); add(134, O_HIGH, 3);
    exp_step(144);

    rst = 1'b1; buttons = 4'd0; pause_btn = 1'b0; dead = 1'b0;
    eat_s = 1'b0; badh_s = 1'b0; badv_s = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int c = 0; c <= LAST_CYC; c++) begin
      // Scoreboard: every step pulse must match the oldest queued expectation.
      if (step) begin
        if (step_sb.size() == 0) begin
          check("step_unexpected", c, 1, 0);
        end else begin
          int exp_c;
          exp_c = step_sb.pop_front();
          check("step_cycle", c, c, exp_c);
        end
      end
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c && tbl[i].kind >= O_STATE && tbl[i].kind <= O_STEP)
          check(tbl[i].kind.name(), c, get_out(tbl[i].kind), tbl[i].val);
      end
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c && (tbl[i].kind < O_STATE || tbl[i].kind == X_STEP))
          drive(tbl[i].kind, tbl[i].val);
      end
      @(posedge clk);
      #1;
    end
    check("steps_outstanding", LAST_CYC, step_sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snek_game_ctrl.md
# snek_game_ctrl

Parametrised game-control core for the snek VGA game. It sits between the board buttons and the snake and food generators, and owns four things: the game state machine (splash, play, pause, game over), the snake step timer, direction arbitration, and eat/score bookkeeping. Compared with the previous top-level logic it adds:
- a configurable grid size;
- a speed curve with a floor;
- rejection of reverse-direction input;
- pause;
- a timed game-over hold;
- a high score that persists across games.

## Interface
Parameters:
- GRID_W, 32, grid columns.
- GRID_H, 24, grid rows.
- H_BITS, 6, width of horizontal coordinates.
- V_BITS, 6, width of vertical coordinates.
- SCORE_W, 8, score width.
- TICK_START, 6250000, step period in clk cycles at score 0.
- TICK_STEP, 200000, period reduction per point scored.
- TICK_MIN, 1250000, floor on the step period.
- SPLASH_CYCLES, 125000000, splash duration in clk cycles.
- OVER_CYCLES, 25000000, game-over hold in clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- buttons  in  4  level inputs: [0] right, [1] left, [2] up, [3] down.
- pause_btn  in  1  level input; a rising edge toggles pause.
- head_h  in  H_BITS  snake head column.
- head_v  in  V_BITS  snake head row.
- food_h  in  H_BITS  food column.
- food_v  in  V_BITS  food row.
- dead  in  1  collision flag from the snake generator.
- step  out  1  one-cycle pulse that advances the snake.
- dir  out  2  committed direction: 0 left, 1 right, 2 up, 3 down.
- grow  out  1  level; snake grows on the next step.
- new_food  out  1  one-cycle pulse requesting a food relocation.
- game_rst  out  1  one-cycle pulse resetting the snake generator.
- state  out  2  0 SPLASH, 1 PLAY, 2 PAUSE, 3 OVER.
- score  out  SCORE_W  current score.
- high_score  out  SCORE_W  best score since rst.

## Operation
- **SPLASH**
  - Counts SPLASH_CYCLES clk cycles, then enters PLAY.
  - On entry to PLAY, pulses game_rst and new_food in the same cycle.
- **PLAY**
  - The step counter runs and emits step when count == period-1, then the counter clears.
  - period = max(TICK_MIN, TICK_START - TICK_STEP*score).
    - Computed at 32 bits.
    - If TICK_STEP*score > TICK_START - TICK_MIN, period = TICK_MIN.
    - The period register updates only on a step cycle.
- **PAUSE**
  - A pause_btn rising edge in PLAY enters PAUSE; another rising edge returns to PLAY.
  - While paused, the step counter, eat detection and direction commit are frozen.
  - Button input is still latched while paused.
  - pause_btn edges are ignored in SPLASH and OVER.
- **Direction**
  - Every cycle, the pending direction is latched from buttons with priority left > right > up > down.
  - A request equal to the reverse of the committed dir ({dir[1], ~dir[0]}) is discarded.
  - pending is copied to dir on each step. dir is constant between steps.
- **Eat**
  - In PLAY, when head_h == food_h, head_v == food_v and eat_armed is 1:
    - new_food pulses;
    - score increments, saturating at 2^SCORE_W-1;
    - grow is set;
    - eat_armed clears.
  - grow and eat_armed are restored by the next step: grow clears and eat_armed sets in the cycle after the step pulse, so the snake generator samples grow=1 on that step.
- **Bad food**: if food_h >= GRID_W or food_v >= GRID_H in PLAY or PAUSE, new_food pulses every cycle until the position is legal. No score is awarded.
- **Death**
  - dead=1 in PLAY moves the FSM to OVER on the next cycle.
  - high_score <= score if score > high_score.
  - dead is ignored in SPLASH, PAUSE and OVER.
- **OVER**
  - Holds OVER_CYCLES; step stays 0.
  - Then enters PLAY with game_rst and new_food pulsing in the same cycle.
  - In that same cycle: score clears, dir is set to 0, pending is set to 0, the step counter clears and period is set to TICK_START.
- **Simultaneous events**
  - dead and an eat in the same cycle: the eat is counted before high_score is compared.
  - A pause edge in the same cycle as dead: dead wins.

## Timing
- **Reset values**:
  - state=SPLASH;
  - step=0, grow=0, new_food=0, game_rst=0;
  - dir=0;
  - score=0, high_score=0;
  - all counters 0;
  - eat_armed=1.
- rst mid-game returns everything to the reset values on the next edge. rst is the only clear of high_score; game_rst does not clear it.
- All outputs are registered.
- step is exactly one cycle wide, and consecutive steps are exactly period cycles apart.
- A button press reaches dir at the first step at least 2 cycles after the press.
- Eat response: new_food pulses and score increments 1 cycle after the coincidence.
- The PLAY→OVER transition happens 1 cycle after dead is asserted.

## Test plan
Bench parameters: TICK_START=10, TICK_STEP=2, TICK_MIN=4, SPLASH_CYCLES=5, OVER_CYCLES=3, GRID 32x24.
- **Reset and splash**: rst for 2 cycles, then idle.
  - state=0 for 5 cycles, then state=1 with game_rst=new_food=1 for one cycle.
  - First step arrives 10 cycles later.
- **Speed curve**: force 4 eats. Step spacing is 10, then 8, 6, 4, and stays 4 at score 5 (floor).
- **Reverse rejection**: dir=1 (right), press left → dir stays 1 after the next step. Press up → dir=2 after the next step.
- **Eat with a held head**: head equals food for 15 cycles across one step.
  - score increments exactly once.
  - grow=1 up to and including the step cycle, 0 afterwards.
- **Pause**: a pause edge mid-period freezes the counter for 20 cycles, with no step. A second edge resumes, and the remaining count completes unchanged.
- **Death and high score**: score=3, pulse dead.
  - state=3 next cycle; high_score=3.
  - After 3 cycles: state=1, game_rst pulses, score=0, high_score=3.
  - A following game ending with score 2 leaves high_score=3.
